// File: rtl/move_dma_if.sv
// ---------------------------------------------------------------------------
// move_dma_if : memory command/response bus between the block-copy engine and
//               the coprocessor memory port. One command may be outstanding.
//
//   cmd_valid / cmd_ready  command handshake (engine -> memory)
//   cmd_read               1 = read, 0 = write
//   cmd_addr  [AW]         command byte address
//   cmd_wdata [DW]         write data
//   rsp_valid / rsp_ready  response handshake (memory -> engine)
//   rsp_rdata [DW]         read data
//   rsp_err                response error
//
//   modport master : the engine side (issues commands, accepts responses)
//   modport slave  : the memory side
// ---------------------------------------------------------------------------
interface move_dma_if #(
  parameter int AW = 32,
  parameter int DW = 16
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid,
    output cmd_read,
    output cmd_addr,
    output cmd_wdata,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_read,
    input  cmd_addr,
    input  cmd_wdata,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface : move_dma_if

// File: rtl/move_dma.sv
// ---------------------------------------------------------------------------
// move_dma : block-copy engine fed by the coprocessor register file.
//
// After a one-cycle start it copies len DW-bit elements from the source to the
// destination address, one read followed by one write per element, over a
// single-outstanding command/response bus. Both addresses advance by STEP
// bytes per element and wrap modulo 2^AW. A response error ends the copy at
// once (no further command), sets the sticky err flag and still pulses done.
//
// Ports
//   clk                      clock
//   reset                    asynchronous active-low reset; aborts any copy
//   start                    one-cycle copy request, honoured only when idle
//   sor_addr_hi/sor_addr_lo  source address [31:16] / [15:0]
//   des_addr_hi/des_addr_lo  destination address [31:16] / [15:0]
//   len                      element count (0 = no transfer, done only)
//   busy                     high in every state but idle
//   done                     one-cycle completion pulse
//   err                      bus error seen in the last copy (sticky)
//   remain                   elements still to copy
//   mem                      memory bus, master side
//
// Timing with a zero-wait memory: start accepted in cycle 0, first command in
// cycle 1, four cycles per element, done in cycle 4*len+1 (cycle 1 if len=0).
// ---------------------------------------------------------------------------
module move_dma #(
  parameter int AW   = 32,
  parameter int DW   = 16,
  parameter int STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] sor_addr_hi,
  input  logic [15:0] sor_addr_lo,
  input  logic [15:0] des_addr_hi,
  input  logic [15:0] des_addr_lo,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] remain,
  move_dma_if.master  mem
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [AW-1:0] ADDR_STEP = AW'(STEP);

  state_t        state_q;
  state_t        state_d;

  logic [AW-1:0] src_q;     // address of the next element to read
  logic [AW-1:0] dst_q;     // address of the next element to write
  logic [DW-1:0] data_q;    // element held between its read and its write
  logic [15:0]   remain_q;
  logic          err_q;

  logic          rsp_fire;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples values from before the edge; blocking here would let one
  // register see another's new value within the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and bus outputs. Command fields come straight from the state
  // and the address/data registers, which do not change while a command
  // waits for cmd_ready, so the command is stable until accepted. Because
  // they are decoded from the state register, an asynchronous reset drops
  // cmd_valid and rsp_ready in the same instant.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    busy          = 1'b1;
    done          = 1'b0;
    mem.cmd_valid = 1'b0;
    mem.cmd_read  = 1'b0;
    mem.cmd_addr  = src_q;
    mem.cmd_wdata = data_q;
    mem.rsp_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (len != 16'd0) ? ST_RD_REQ : ST_DONE;
        end
      end

      ST_RD_REQ: begin
        mem.cmd_valid = 1'b1;
        mem.cmd_read  = 1'b1;
        mem.cmd_addr  = src_q;
        if (mem.cmd_ready) begin
          state_d = ST_RD_RSP;
        end
      end

      ST_RD_RSP: begin
        mem.rsp_ready = 1'b1;
        if (mem.rsp_valid) begin
          // A failed read ends the copy without issuing its write.
          state_d = mem.rsp_err ? ST_DONE : ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        mem.cmd_valid = 1'b1;
        mem.cmd_read  = 1'b0;
        mem.cmd_addr  = dst_q;
        mem.cmd_wdata = data_q;
        if (mem.cmd_ready) begin
          state_d = ST_WR_RSP;
        end
      end

      ST_WR_RSP: begin
        mem.rsp_ready = 1'b1;
        if (mem.rsp_valid) begin
          // remain_q still holds the pre-decrement count here, so 1 means
          // this write completed the last element.
          if (mem.rsp_err || (remain_q == 16'd1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here: the request would be
        // lost rather than queued behind the finishing copy.
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_fire = mem.rsp_valid & mem.rsp_ready;

  // -------------------------------------------------------------------------
  // Descriptor, data and status registers. The descriptor inputs are only
  // sampled on an accepted start; afterwards the register file is free to
  // change them without disturbing the running copy.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these are individual flops, not a memory array, so resetting
      // them is cheap and keeps cmd_addr/cmd_wdata at zero out of reset.
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q    <= AW'({sor_addr_hi, sor_addr_lo});
            dst_q    <= AW'({des_addr_hi, des_addr_lo});
            remain_q <= len;
            err_q    <= 1'b0;
          end
        end

        ST_RD_RSP: begin
          if (rsp_fire) begin
            if (mem.rsp_err) begin
              err_q <= 1'b1;
            end else begin
              data_q <= mem.rsp_rdata;
            end
          end
        end

        ST_WR_RSP: begin
          if (rsp_fire) begin
            if (mem.rsp_err) begin
              // The failed element is not counted as copied.
              err_q <= 1'b1;
            end else begin
              remain_q <= remain_q - 16'd1;
              src_q    <= src_q + ADDR_STEP;   // wraps modulo 2^AW
              dst_q    <= dst_q + ADDR_STEP;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign remain = remain_q;
  assign err    = err_q;

endmodule : move_dma

// File: doc/move_dma.md
Name: move_dma

Overview:
- Block-copy engine that consumes the descriptor registers held by the coprocessor register file: source address, destination address and length.
- After a start pulse it copies N 16-bit elements from source to destination over a single-outstanding memory command/response bus.
- It then pulses done and reports any bus error.
- It sits directly downstream of the register file and upstream of the coprocessor's memory port.

Parameters:
- AW, 32, memory address width; address = {reg1, reg0} of the 16-bit address register pairs.
- DW, 16, data element width.
- STEP, 2, byte increment applied to both addresses per element.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a copy.
- sor_addr_hi  in  16  source address [31:16].
- sor_addr_lo  in  16  source address [15:0].
- des_addr_hi  in  16  destination address [31:16].
- des_addr_lo  in  16  destination address [15:0].
- len  in  16  element count, unsigned.
- busy  out  1  copy in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky bus-error flag for the last copy.
- remain  out  16  elements still to copy.
- cmd_valid  out  1  memory command valid.
- cmd_ready  in  1  memory command accepted.
- cmd_read  out  1  1 = read, 0 = write.
- cmd_addr  out  AW  command byte address.
- cmd_wdata  out  DW  write data.
- rsp_valid  in  1  memory response valid.
- rsp_ready  out  1  response accept.
- rsp_rdata  in  DW  read data.
- rsp_err  in  1  response error.

Behaviour:
- Reset (reset = 0, asynchronous, effective immediately): state IDLE.
  - busy, done, err, cmd_valid, rsp_ready, cmd_read = 0.
  - cmd_addr, cmd_wdata, remain = 0; internal address/data registers = 0.
  - Reset mid-copy aborts with no done pulse. cmd_valid drops in the same instant, so an in-flight transaction is abandoned.
- States: IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, DONE.
- IDLE:
  - On start = 1: latch src = {sor_addr_hi, sor_addr_lo}, dst = {des_addr_hi, des_addr_lo}, remain = len; clear err.
  - Next state is RD_REQ if len != 0, else DONE.
  - start in any other state is ignored; the descriptor inputs are sampled only on the accepted start.
- busy = 1 in every state except IDLE, including DONE.
- RD_REQ: cmd_valid = 1, cmd_read = 1, cmd_addr = src. On cmd_valid & cmd_ready go to RD_RSP. cmd_valid and the command fields stay stable until accepted.
- RD_RSP: rsp_ready = 1. On rsp_valid:
  - If rsp_err = 1: set err and go to DONE; no write is issued and remain is not decremented.
  - Otherwise latch rsp_rdata and go to WR_REQ.
- WR_REQ: cmd_valid = 1, cmd_read = 0, cmd_addr = dst, cmd_wdata = latched data. On handshake go to WR_RSP.
- WR_RSP: rsp_ready = 1. On rsp_valid:
  - If rsp_err = 1: set err and go to DONE.
  - Otherwise: remain -= 1, src += STEP, dst += STEP. Go to DONE if remain was 1, else RD_REQ.
- DONE: done = 1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Arithmetic and boundaries:
  - Address increments wrap modulo 2^AW; no overlap check.
  - len = 0xFFFF copies 65535 elements.
  - rsp_valid outside RD_RSP/WR_RSP is ignored (rsp_ready = 0).
- Zero-wait latency: start accepted in cycle 0 gives the first cmd_valid in cycle 1.
  - Each element takes 4 cycles.
  - done is high in cycle 4N+1; for len = 0, done is high in cycle 1.
- err stays valid until the next accepted start.

Test Plan:
- Reset values: assert reset low mid-RD_RSP, copying len = 5 -> busy, cmd_valid, rsp_ready and remain = 0 immediately; no done pulse; the next start copies normally.
- Zero-wait copy: start with src = 0x0000_1000, dst = 0x0000_2000, len = 3; memory holds 0xAAAA, 0xBBBB, 0xCCCC.
  - Required: reads at 0x1000/0x1002/0x1004 and writes at 0x2000/0x2002/0x2004 with the matching data.
  - done in cycle 13; err = 0; remain steps 3 -> 2 -> 1 -> 0.
- Backpressure: same copy with cmd_ready low for 3 cycles on each command and rsp_valid delayed 2 cycles.
  - Command fields are held stable while stalled; data is correct.
  - done occurs 5 cycles later per transaction than in the zero-wait run.
- len = 0: start -> no cmd_valid ever; done in cycle 1; busy high in cycle 1 only.
- Read error: len = 4, rsp_err = 1 on the second read -> exactly one write is issued (to dst); err = 1, remain = 3; done pulse; err cleared by the next start.
- Wrap and ignored start: src = 0xFFFF_FFFE, len = 2 -> second read at 0x0000_0000. A start pulsed while busy with different descriptors has no effect.
